// File: rtl/hls_bridge_buffered.sv
// hls_bridge_buffered: CPU simple bus (cmd/rsp) to HLS ap_fifo bridge.
// Commands are packed into one word and buffered in a first-word-fall-through
// FIFO. Reads in flight are counted and capped. Response beats are registered
// for one cycle of latency before they reach the bus.
module hls_bridge_buffered #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int CMD_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MASK_WIDTH      = DATA_WIDTH / 8,
    parameter int CMD_WIDTH       = DATA_ADDR_WIDTH + DATA_WIDTH + MASK_WIDTH + 7
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 io_bus_cmd_valid,
    output logic                                 io_bus_cmd_ready,
    input  logic [DATA_ADDR_WIDTH-1:0]           io_bus_cmd_payload_address,
    input  logic [DATA_WIDTH-1:0]                io_bus_cmd_payload_data,
    input  logic [MASK_WIDTH-1:0]                io_bus_cmd_payload_mask,
    input  logic                                 io_bus_cmd_payload_write,
    input  logic                                 io_bus_cmd_payload_uncached,
    input  logic [2:0]                           io_bus_cmd_payload_size,
    input  logic                                 io_bus_cmd_payload_last,
    output logic                                 io_bus_rsp_valid,
    output logic [DATA_WIDTH-1:0]                io_bus_rsp_payload_data,
    output logic                                 io_bus_rsp_payload_last,
    output logic [CMD_WIDTH-1:0]                 hls_cmd_din,
    input  logic                                 hls_cmd_full_n,
    output logic                                 hls_cmd_write,
    input  logic [DATA_WIDTH:0]                  hls_rsp_dout,
    input  logic                                 hls_rsp_empty_n,
    output logic                                 hls_rsp_read,
    output logic [$clog2(CMD_DEPTH):0]           cmd_level,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 rsp_orphan
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int LW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(CMD_DEPTH);
    localparam logic [OW-1:0] MAXO_L  = OW'(MAX_OUTSTANDING);

    logic [CMD_WIDTH-1:0]  cmd_mem [CMD_DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [LW-1:0]         level_reg;
    logic [OW-1:0]         outstanding_reg;
    logic                  orphan_reg;
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic                  rsp_last_reg;

    logic                  cmd_ready;
    logic                  cmd_accept;
    logic                  cmd_pop;
    logic                  rsp_pop;
    logic                  rsp_pop_last;
    logic                  read_inc;
    logic                  read_dec;
    logic [CMD_WIDTH-1:0]  cmd_packed;

    // The packed word has one spare bit beyond the listed fields; it sits at
    // bit 0 and is always zero so that the address stays in the MSBs.
    assign cmd_packed = {io_bus_cmd_payload_address, io_bus_cmd_payload_data,
                         io_bus_cmd_payload_mask, io_bus_cmd_payload_write,
                         io_bus_cmd_payload_uncached, io_bus_cmd_payload_size,
                         io_bus_cmd_payload_last, 1'b0};

    // Ready uses only registered state: a full FIFO never accepts, even when
    // the head is being popped in the same cycle.
    assign cmd_ready    = ~rst & (level_reg < DEPTH_L)
                        & (io_bus_cmd_payload_write | (outstanding_reg < MAXO_L));
    assign cmd_accept   = io_bus_cmd_valid & cmd_ready;
    assign cmd_pop      = ~rst & (level_reg != '0) & hls_cmd_full_n;
    assign rsp_pop      = ~rst & hls_rsp_empty_n;
    assign rsp_pop_last = rsp_pop & hls_rsp_dout[DATA_WIDTH];
    assign read_inc     = cmd_accept & ~io_bus_cmd_payload_write & io_bus_cmd_payload_last;
    assign read_dec     = rsp_pop_last & (outstanding_reg != '0);

    assign io_bus_cmd_ready        = cmd_ready;
    assign hls_cmd_write           = ~rst & (level_reg != '0);
    assign hls_cmd_din             = rst ? '0 : cmd_mem[rd_ptr_reg];
    assign hls_rsp_read            = rsp_pop;
    assign io_bus_rsp_valid        = ~rst & rsp_valid_reg;
    assign io_bus_rsp_payload_data = rst ? '0 : rsp_data_reg;
    assign io_bus_rsp_payload_last = ~rst & rsp_last_reg;
    assign cmd_level               = rst ? '0 : level_reg;
    assign outstanding             = rst ? '0 : outstanding_reg;
    assign rsp_orphan              = ~rst & orphan_reg;

    // Command storage: written on accept, head read combinationally (FWFT).
    always_ff @(posedge clk) begin
        if (cmd_accept) begin
            cmd_mem[wr_ptr_reg] <= cmd_packed;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at CMD_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (cmd_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (cmd_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({cmd_accept, cmd_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Read tracking: count reads in flight, flag last beats with none pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_reg <= '0;
            orphan_reg      <= 1'b0;
        end else begin
            case ({read_inc, read_dec})
                2'b10:   outstanding_reg <= outstanding_reg + OW'(1);
                2'b01:   outstanding_reg <= outstanding_reg - OW'(1);
                default: outstanding_reg <= outstanding_reg;
            endcase
            if (rsp_pop_last && outstanding_reg == '0) begin
                orphan_reg <= 1'b1;
            end
        end
    end

    // Response register: every popped beat is presented on the bus next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_last_reg  <= 1'b0;
        end else begin
            rsp_valid_reg <= rsp_pop;
            if (rsp_pop) begin
                rsp_data_reg <= hls_rsp_dout[DATA_WIDTH-1:0];
                rsp_last_reg <= hls_rsp_dout[DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_hls_bridge_buffered.sv
// Testbench for hls_bridge_buffered: directed scenarios plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_hls_bridge_buffered;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = DW / 8;
    localparam int CW = AW + DW + MW + 7;
    localparam int CD = 4;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;
    logic [MW-1:0] mask = '0;
    logic          wr = 1'b0;
    logic          unc = 1'b0;
    logic [2:0]    size = '0;
    logic          last = 1'b0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic [CW-1:0] hls_cmd_din;
    logic          full_n = 1'b1;
    logic          hls_cmd_write;
    logic [DW:0]   dout = '0;
    logic          empty_n = 1'b0;
    logic          hls_rsp_read;
    logic [2:0]    cmd_level;
    logic [2:0]    outstanding;
    logic          rsp_orphan;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hls_bridge_buffered #(
        .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .CMD_DEPTH(CD), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .io_bus_cmd_valid(cmd_valid), .io_bus_cmd_ready(cmd_ready),
        .io_bus_cmd_payload_address(addr), .io_bus_cmd_payload_data(data),
        .io_bus_cmd_payload_mask(mask), .io_bus_cmd_payload_write(wr),
        .io_bus_cmd_payload_uncached(unc), .io_bus_cmd_payload_size(size),
        .io_bus_cmd_payload_last(last),
        .io_bus_rsp_valid(rsp_valid), .io_bus_rsp_payload_data(rsp_data),
        .io_bus_rsp_payload_last(rsp_last),
        .hls_cmd_din(hls_cmd_din), .hls_cmd_full_n(full_n), .hls_cmd_write(hls_cmd_write),
        .hls_rsp_dout(dout), .hls_rsp_empty_n(empty_n), .hls_rsp_read(hls_rsp_read),
        .cmd_level(cmd_level), .outstanding(outstanding), .rsp_orphan(rsp_orphan)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [CW-1:0] mq[$];
    int            mout  = 0;
    bit            morph = 0;
    bit            mrv   = 0;
    bit            mrl   = 0;
    logic [DW-1:0] mrd   = '0;

    function automatic logic [CW-1:0] pack_cmd();
        return {addr, data, mask, wr, unc, size, last, 1'b0};
    endfunction

    // Advance the model on each rising edge using the inputs seen there.
    initial begin
        bit acc, pop, inc, dec;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                mout = 0; morph = 0; mrv = 0;
            end else begin
                acc = cmd_valid && (mq.size() < CD) && (wr || mout < MO);
                pop = (mq.size() != 0) && full_n;
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back(pack_cmd());
                inc = acc && !wr && last;
                dec = 0;
                if (empty_n && dout[DW]) begin
                    if (mout == 0) morph = 1;
                    else dec = 1;
                end
                mout = mout + int'(inc) - int'(dec);
                mrv = empty_n;
                if (empty_n) begin
                    mrd = dout[DW-1:0];
                    mrl = dout[DW];
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        bit exp_ready;
        forever begin
            @(negedge clk);
            exp_ready = !rst && (mq.size() < CD) && (wr || mout < MO);
            chk("cmd_ready", cmd_ready, exp_ready);
            chk("hls_cmd_write", hls_cmd_write, !rst && mq.size() != 0);
            if (!rst && mq.size() != 0) chk("hls_cmd_din", hls_cmd_din, mq[0]);
            chk("cmd_level", cmd_level, rst ? 0 : mq.size());
            chk("outstanding", outstanding, rst ? 0 : mout);
            chk("rsp_orphan", rsp_orphan, rst ? 1'b0 : morph);
            chk("hls_rsp_read", hls_rsp_read, !rst && empty_n);
            chk("rsp_valid", rsp_valid, rst ? 1'b0 : mrv);
            if (!rst && mrv) begin
                chk("rsp_data", rsp_data, mrd);
                chk("rsp_last", rsp_last, mrl);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic w, input logic l);
        addr = a; data = d; mask = '1; wr = w; unc = 1'b0; size = 3'd2; last = l;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic w, input logic l);
        bit acc;
        set_cmd(a, d, w, l);
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            tick();
            if (acc) begin
                cmd_valid = 1'b0;
                $display("[TB] cmd %s addr=%0h data=%0h last=%0b accepted",
                         w ? "write" : "read", a, d, l);
                return;
            end
        end
        cmd_valid = 1'b0;
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got no accept expected accept for addr %0h", a);
    endtask

    task automatic rsp_beat(input logic l, input logic [DW-1:0] d);
        empty_n = 1'b1;
        dout = {l, d};
        tick();
        empty_n = 1'b0;
        $display("[TB] rsp beat last=%0b data=%0h", l, d);
    endtask

    // ---------------- directed and random sequences ----------------
    initial begin
        // Reset with traffic pending on both sides.
        rst = 1'b1; cmd_valid = 1'b1; set_cmd(32'h40, 32'h1, 1'b1, 1'b1);
        empty_n = 1'b1; dout = {1'b1, 32'h1234};
        repeat (3) tick();
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_cmd_write", hls_cmd_write, 1'b0);
        chk("rst_rsp_read", hls_rsp_read, 1'b0);
        rst = 1'b0; cmd_valid = 1'b0; empty_n = 1'b0;
        #1;
        chk("post_rst_ready", cmd_ready, 1'b1);

        // Back-to-back writes with HLS ready.
        full_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(32'h100 + 32'(4 * i), 32'(i), 1'b1, 1'b1);
            chk("b2b_level_le1", cmd_level <= 3'd1, 1'b1);
        end
        repeat (2) tick();

        // Backpressure: four writes fill the FIFO, the fifth waits.
        full_n = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 1'b1);
        set_cmd(32'h210, 32'hA4, 1'b1, 1'b1);
        cmd_valid = 1'b1;
        repeat (3) tick();
        chk("bp_ready", cmd_ready, 1'b0);
        chk("bp_level", cmd_level, 3'd4);
        full_n = 1'b1;
        send(32'h210, 32'hA4, 1'b1, 1'b1);
        repeat (6) tick();
        chk("bp_drained", cmd_level, 3'd0);

        // Outstanding limit.
        for (int i = 0; i < 4; i++) send(32'h300 + 32'(4 * i), 32'h0, 1'b0, 1'b1);
        chk("os_full", outstanding, 3'd4);
        set_cmd(32'h310, 32'h0, 1'b0, 1'b1);
        cmd_valid = 1'b1;
        repeat (3) tick();
        chk("os_read_blocked", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        send(32'h320, 32'h55, 1'b1, 1'b1);
        rsp_beat(1'b1, 32'hDEADBEEF);
        chk("os_rsp_valid", rsp_valid, 1'b1);
        chk("os_rsp_data", rsp_data, 32'hDEADBEEF);
        chk("os_dec", outstanding, 3'd3);
        send(32'h310, 32'h0, 1'b0, 1'b1);
        chk("os_refill", outstanding, 3'd4);

        // Simultaneous increment and decrement at outstanding=2.
        rsp_beat(1'b1, 32'h1);
        rsp_beat(1'b1, 32'h2);
        chk("sim_pre", outstanding, 3'd2);
        set_cmd(32'h400, 32'h0, 1'b0, 1'b1);
        cmd_valid = 1'b1; empty_n = 1'b1; dout = {1'b1, 32'h77};
        tick();
        cmd_valid = 1'b0; empty_n = 1'b0;
        chk("sim_same", outstanding, 3'd2);
        chk("sim_rsp_data", rsp_data, 32'h77);

        // Orphan beat once nothing is outstanding.
        rsp_beat(1'b1, 32'h3);
        rsp_beat(1'b1, 32'h4);
        chk("orph_pre_os", outstanding, 3'd0);
        chk("orph_pre_flag", rsp_orphan, 1'b0);
        rsp_beat(1'b1, 32'h5);
        chk("orph_valid", rsp_valid, 1'b1);
        chk("orph_data", rsp_data, 32'h5);
        chk("orph_flag", rsp_orphan, 1'b1);
        chk("orph_os", outstanding, 3'd0);
        repeat (5) tick();
        chk("orph_sticky", rsp_orphan, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("orph_cleared", rsp_orphan, 1'b0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            set_cmd($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            mask = MW'($urandom);
            unc = 1'($urandom);
            size = 3'($urandom);
            full_n = ($urandom_range(0, 3) != 0);
            empty_n = ($urandom_range(0, 2) == 0);
            dout = {1'($urandom_range(0, 1)), 32'($urandom)};
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; cmd_valid = 1'b0; empty_n = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hls_bridge_buffered.md
Name: hls_bridge_buffered

Overview:
Second-generation bridge between the CPU simple bus (cmd/rsp) and an HLS kernel's ap_fifo ports. It packs all command fields into one HLS stream and decouples the two sides with a parametrised command FIFO. Read requests in flight are tracked and bounded. The response path is registered, and the block exposes status for debug. It sits between the CPU data/peripheral bus and the HLS accelerator top.

Parameters:
DATA_WIDTH, 32, bus data width (multiple of 8)
DATA_ADDR_WIDTH, 32, bus address width
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 4, max reads accepted but not yet answered with last=1 (>=1)
MASK_WIDTH, DATA_WIDTH/8, byte mask width (derived)
CMD_WIDTH, DATA_ADDR_WIDTH+DATA_WIDTH+MASK_WIDTH+7, packed command width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
io_bus_cmd_valid  in  1  command valid
io_bus_cmd_ready  out  1  command accepted when valid&ready
io_bus_cmd_payload_address  in  DATA_ADDR_WIDTH  address
io_bus_cmd_payload_data  in  DATA_WIDTH  write data
io_bus_cmd_payload_mask  in  MASK_WIDTH  byte enables
io_bus_cmd_payload_write  in  1  1=write, 0=read
io_bus_cmd_payload_uncached  in  1  uncached flag
io_bus_cmd_payload_size  in  3  log2 burst size
io_bus_cmd_payload_last  in  1  last beat of command
io_bus_rsp_valid  out  1  response beat valid (no backpressure)
io_bus_rsp_payload_data  out  DATA_WIDTH  read data
io_bus_rsp_payload_last  out  1  last beat of response
hls_cmd_din  out  CMD_WIDTH  packed {address,data,mask,write,uncached,size,last}, address in MSBs
hls_cmd_full_n  in  1  HLS cmd FIFO not full
hls_cmd_write  out  1  HLS cmd FIFO push
hls_rsp_dout  in  DATA_WIDTH+1  {last,data} from HLS
hls_rsp_empty_n  in  1  HLS rsp FIFO not empty
hls_rsp_read  out  1  HLS rsp FIFO pop
cmd_level  out  $clog2(CMD_DEPTH)+1  command FIFO occupancy
outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads in flight
rsp_orphan  out  1  sticky: response beat arrived with outstanding==0

Behaviour:
- Reset is synchronous and active-high; clock is clk. While rst=1: all outputs are 0, the FIFO is empty, counters are 0, and rsp_orphan is cleared. rst mid-transfer discards queued commands and in-flight read tracking.
- io_bus_cmd_ready = ~rst & (cmd_level<CMD_DEPTH) & (write | outstanding<MAX_OUTSTANDING). The ready term depends on payload_write, which is stable while valid is high.
- Accept: packed command is pushed into the FIFO at the clock edge. A read with last=1 increments outstanding.
- Full FIFO does not accept, even if a pop occurs in the same cycle. Ready is based on registered level only.
- FIFO is first-word-fall-through. hls_cmd_write = ~rst & (cmd_level!=0), and hls_cmd_din = head.
- Pop occurs when hls_cmd_write & hls_cmd_full_n. A command appears on hls_cmd_write no earlier than 1 cycle after acceptance. Throughput is 1/cycle when HLS is not full.
- Push and pop in the same cycle leave the level unchanged. Pointers wrap modulo CMD_DEPTH.
- hls_rsp_read = ~rst & hls_rsp_empty_n. A popped beat is registered, giving io_bus_rsp_valid=1 next cycle with data/last from hls_rsp_dout. Otherwise rsp_valid=0. Latency is 1 cycle, sustaining 1 beat/cycle.
- outstanding decrements when a beat with last=1 is popped. Simultaneous inc and dec leave it unchanged.
- If a last=1 beat is popped while outstanding==0: the counter stays 0, the beat is still forwarded, and rsp_orphan is set until rst.
- Writes produce no response tracking.

Test Plan:
- Reset: hold rst 3 cycles with cmd_valid=1 and hls_rsp_empty_n=1 -> all outputs 0, no hls_cmd_write, no hls_rsp_read; after release, cmd_ready=1.
- Back-to-back writes: 6 writes at address 0x100+4i, data i, mask 0xF, hls_cmd_full_n=1 -> 6 hls_cmd_write pulses in order, first one cycle after first accept, cmd_level never exceeds 1.
- Backpressure: hls_cmd_full_n=0 and 5 writes offered -> 4 accepted, cmd_ready=0 with cmd_level=4. Raise full_n -> 4 pops over 4 consecutive cycles, 5th command then accepted.
- Outstanding limit: 5 reads offered with no responses -> 4 accepted, outstanding=4, ready=0 for the read. A write offered meanwhile is accepted. One rsp beat {last=1,0xDEADBEEF} -> rsp_valid next cycle with 0xDEADBEEF, outstanding=3, 5th read accepted.
- Simultaneous events: accept a read in the same cycle a last=1 beat is popped with outstanding=2 -> outstanding stays 2.
- Orphan: with outstanding=0, push beat {last=1,0x5} -> rsp_valid with 0x5, rsp_orphan=1 persists until rst.
